// File: rtl/regwr_arbiter.sv
// regwr_arbiter: round-robin arbiter for the register-file write port, registered output stage.
// Optional destination-register scoreboard when REGWR_SCOREBOARD_EN is defined.
module regwr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              regwrite,
  output logic [AW-1:0]     wrreg,
  output logic [DW-1:0]     wrdata,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_reg,
  input  logic [AW-1:0]     read1,
  input  logic [AW-1:0]     read2,
  input  logic [AW-1:0]     read3,
  output logic              busy1,
  output logic              busy2,
  output logic              busy3
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [AW-1:0] regs [NREQ];
  logic [DW-1:0] datas [NREQ];
  logic [PW-1:0] rr_q, rr_d, win, idx;
  logic          found;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] wrreg_q, wrreg_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign regs[i]  = req_reg[i*AW +: AW];
    assign datas[i] = req_data[i*DW +: DW];
  end
  // first valid requester at or after rr_q, wrapping; data never enters this path
  always_comb begin
    req_ready = '0;
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        req_ready[idx] = 1'b1;
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    rr_d       = found ? PW'((int'(win) + 1) % NREQ) : rr_q;
    regwrite_d = found && regs[win] != '0;
    wrreg_d    = found ? regs[win] : wrreg_q;
    wrdata_d   = found ? datas[win] : wrdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      regwrite_q <= 1'b0;
      wrreg_q    <= '0;
      wrdata_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      regwrite_q <= regwrite_d;
      wrreg_q    <= wrreg_d;
      wrdata_q   <= wrdata_d;
    end
  end
  assign regwrite = regwrite_q;
  assign wrreg    = wrreg_q;
  assign wrdata   = wrdata_q;
`ifdef REGWR_SCOREBOARD_EN
  logic [(1<<AW)-1:0] busy_q, busy_d;
  // a reservation at the commit edge of the same register wins over the clear
  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) busy_d[wrreg_q] = 1'b0;
    if (rsv_valid) busy_d[rsv_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign busy1 = busy_q[read1];
  assign busy2 = busy_q[read2];
  assign busy3 = busy_q[read3];
`else
  logic unused_sb;
  assign unused_sb = ^{rsv_valid, rsv_reg, read1, read2, read3};
  assign busy1 = 1'b0;
  assign busy2 = 1'b0;
  assign busy3 = 1'b0;
`endif
endmodule
